dmem_access_unit: RTL and testbench

Data-memory access controller in the MEM stage of the RISC-V core, directly upstream of the load-data formatter. It turns a load or store from the pipeline into a request/grant/valid transaction on the data-memory port, and generates byte enables and lane-replicated store data. It stalls the pipeline until the access completes, then presents the raw 32-bit read word, the latched byte offset and funct3 for sign/zero extension downstream.

---
 rtl/dmem_access_unit_if.sv | 14 +
 rtl/dmem_access_unit.sv | 148 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Data-memory port between dmem_access_unit (master) and the data memory (slave).
interface dmem_access_unit_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store controller driving a req/gnt/rvalid data-memory port.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module dmem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               done,
  output logic [31:0]        rdata,
  output logic [1:0]         byte_index,
  output logic [2:0]         mem_select,
  output logic               bus_error,
  output logic               misaligned,
  dmem_access_unit_if.master dmem
);
  localparam int cnt_w = $clog2(TIMEOUT) + 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic             is_store;
  logic [1:0]       op_offset;
  logic [2:0]       op_funct3;
  logic             start;
  logic             busy;
  logic             complete;
  logic             expire;
  logic             addr_misaligned;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;

  assign start    = mem_read | mem_write;
  assign stall    = ((state == IDLE) & start) | (state == REQ) | (state == RESP);
  assign busy     = (state == REQ) | (state == RESP);
  assign complete = ((state == REQ) & dmem.gnt & is_store) | ((state == RESP) & dmem.rvalid);
  // A load granted on the very last allowed cycle still aborts: no room left for the response.
  assign expire   = busy & ~complete & (cnt >= cnt_last);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign addr_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                           ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
  assign addr_misaligned = 1'b0;
`endif

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = wdata;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << addr[1:0];
          req_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          req_be    = addr[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_store   <= 1'b0;
      op_offset  <= 2'b00;
      op_funct3  <= 3'b000;
      done       <= 1'b0;
      rdata      <= '0;
      byte_index <= 2'b00;
      mem_select <= 3'b000;
      bus_error  <= 1'b0;
      misaligned <= 1'b0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.be    <= 4'b0000;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
    end else begin
      done       <= 1'b0;
      bus_error  <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_store  <= mem_write;
            op_offset <= addr[1:0];
            op_funct3 <= funct3;
            if (addr_misaligned) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
              byte_index <= addr[1:0];
              mem_select <= funct3;
            end else begin
              state      <= REQ;
              cnt        <= '0;
              dmem.req   <= 1'b1;
              dmem.we    <= mem_write;
              dmem.be    <= req_be;
              dmem.addr  <= {addr[31:2], 2'b00};
              dmem.wdata <= req_wdata;
            end
          end
        end
        REQ: begin
          if (dmem.gnt) begin
            dmem.req <= 1'b0;
            state    <= is_store ? DONE : RESP;
          end
        end
        RESP: begin
          if (dmem.rvalid) begin
            rdata <= dmem.rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (busy) cnt <= cnt + 1'b1;
      if (complete | expire) begin
        done       <= 1'b1;
        byte_index <= op_offset;
        mem_select <= op_funct3;
      end
      // Timeout takes precedence over whatever the case statement chose.
      if (expire) begin
        state     <= DONE;
        bus_error <= 1'b1;
        rdata     <= '0;
        dmem.req  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit: per-cycle compare against a transaction-level model,
// plus a few directed transactions pinned with literal expectations.
module tb_dmem_access_unit;
  localparam int TIMEOUT = 16;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  byte_index;
  logic [2:0]  mem_select;
  logic        bus_error;
  logic        misaligned;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .byte_index (byte_index),
    .mem_select (mem_select),
    .bus_error  (bus_error),
    .misaligned (misaligned),
    .dmem       (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        done;
    logic        req;
    logic        we;
    logic        berr;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [1:0]  bi;
    logic [2:0]  ms;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [31:0] m_rdata = '0;
  logic [1:0]  m_bi    = '0;
  logic [2:0]  m_ms    = '0;

  int          obs_stall = 0;
  int          obs_req   = 0;
  int          obs_done_stalls = 0;
  int          obs_done_reqs   = 0;
  logic [31:0] obs_addr  = '0;
  logic [31:0] obs_wdata = '0;
  logic [31:0] obs_rdata = '0;
  logic [3:0]  obs_be    = '0;
  logic        obs_we    = 1'b0;
  logic        obs_berr  = 1'b0;

  logic [2:0] load_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] store_f3 [3] = '{3'b000, 3'b001, 3'b010};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Every queued cycle is compared mid-cycle; observations feed the directed literal checks.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput("stall", 32'(stall), 32'(cur.stall));
      checkOutput("done", 32'(done), 32'(cur.done));
      checkOutput("dmem_req", 32'(bus.req), 32'(cur.req));
      checkOutput("rdata", rdata, cur.rdata);
      checkOutput("byte_index", 32'(byte_index), 32'(cur.bi));
      checkOutput("mem_select", 32'(mem_select), 32'(cur.ms));
      if (cur.req) begin
        checkOutput("dmem_addr", bus.addr, cur.addr);
        checkOutput("dmem_be", 32'(bus.be), 32'(cur.be));
        checkOutput("dmem_we", 32'(bus.we), 32'(cur.we));
        if (cur.we) checkOutput("dmem_wdata", bus.wdata, cur.wdata);
      end
      if (cur.done) begin
        checkOutput("bus_error", 32'(bus_error), 32'(cur.berr));
        checkOutput("misaligned", 32'(misaligned), 32'(cur.mis));
      end
      if (stall) obs_stall++;
      if (bus.req) begin
        obs_req++;
        obs_addr  = bus.addr;
        obs_be    = bus.be;
        obs_we    = bus.we;
        obs_wdata = bus.wdata;
      end
      if (done) begin
        obs_done_stalls = obs_stall;
        obs_done_reqs   = obs_req;
        obs_rdata       = rdata;
        obs_berr        = bus_error;
        obs_stall       = 0;
        obs_req         = 0;
      end
    end
  end

  function automatic exp_t holdExp();
    exp_t e;
    e       = '{default: '0};
    e.rdata = m_rdata;
    e.bi    = m_bi;
    e.ms    = m_ms;
    return e;
  endfunction

  // One transaction: memory grants after gnt_dly wait cycles and answers loads rv_dly cycles after gnt.
  task automatic applyStimulus(input logic st, input logic both, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                               input int rv_dly, input logic [31:0] rd, input int idle);
    exp_t        e;
    int          n, off, busy, req_cycles, rv_at;
    logic        berr, mis;
    logic [3:0]  be;
    logic [31:0] bwd;

    mis = TRAP_EN && (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)));
    n   = st ? (1 << f3[1:0]) : 4;
    off = int'(a[1:0]) & ~(n - 1);
    be  = 4'(((1 << n) - 1) << off);
    for (int k = 0; k < 4; k++) bwd[8*k +: 8] = wd[8*(k % n) +: 8];

    if (mis) begin
      berr = 1'b0; busy = 0; req_cycles = 0;
    end else if (st) begin
      berr = (gnt_dly >= TIMEOUT);
      busy = berr ? TIMEOUT : gnt_dly + 1;
      req_cycles = busy;
    end else begin
      berr = (gnt_dly + rv_dly + 2 > TIMEOUT);
      busy = berr ? TIMEOUT : gnt_dly + rv_dly + 2;
      req_cycles = (gnt_dly + 1 < busy) ? gnt_dly + 1 : busy;
    end
    rv_at = gnt_dly + 1 + rv_dly;

    mem_write  = st;
    mem_read   = !st || both;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'($urandom_range(0, 1));
    bus.rdata  = $urandom();
    e = holdExp();
    e.stall = 1'b1;
    exp_q.push_back(e);
    @(posedge clock); #1;

    for (int i = 0; i < busy; i++) begin
      funct3 = 3'($urandom());
      addr   = $urandom();
      wdata  = $urandom();
      e = holdExp();
      e.stall = 1'b1;
      if (i < req_cycles) begin
        e.req      = 1'b1;
        e.addr     = {a[31:2], 2'b00};
        e.be       = be;
        e.we       = st;
        e.wdata    = bwd;
        bus.gnt    = (i == gnt_dly);
        bus.rvalid = 1'($urandom_range(0, 1));
        bus.rdata  = $urandom();
      end else begin
        bus.gnt    = 1'b0;
        bus.rvalid = (i == rv_at);
        bus.rdata  = (i == rv_at) ? rd : $urandom();
      end
      exp_q.push_back(e);
      @(posedge clock); #1;
    end

    if (berr) m_rdata = '0;
    else if (!st && !mis) m_rdata = rd;
    m_bi = a[1:0];
    m_ms = f3;
    e = holdExp();
    e.done     = 1'b1;
    e.berr     = berr;
    e.mis      = mis;
    mem_read   = 1'($urandom_range(0, 1));
    mem_write  = 1'($urandom_range(0, 1));
    bus.gnt    = 1'b0;
    bus.rvalid = 1'($urandom_range(0, 1));
    bus.rdata  = $urandom();
    exp_q.push_back(e);
    @(posedge clock); #1;

    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < idle; i++) begin
      bus.rvalid = 1'($urandom_range(0, 1));
      exp_q.push_back(holdExp());
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    int          gd, rvd;

    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    wdata      = '0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_req", 32'(bus.req), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_be", 32'(bus.be), 32'd0);
    @(posedge clock); #1;

    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1);
    checkOutput("lw_stall_cycles", 32'(obs_done_stalls), 32'd3);
    checkOutput("lw_addr", obs_addr, 32'h0000_0100);
    checkOutput("lw_be", 32'(obs_be), 32'hF);
    checkOutput("lw_rdata", obs_rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0, 1);
    checkOutput("sb_stall_cycles", 32'(obs_done_stalls), 32'd2);
    checkOutput("sb_be", 32'(obs_be), 32'h8);
    checkOutput("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_we", 32'(obs_we), 32'd1);

    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 3, 0, 32'h0, 0);
    checkOutput("sh_req_cycles", 32'(obs_done_reqs), 32'd4);
    checkOutput("sh_stall_cycles", 32'(obs_done_stalls), 32'd5);
    checkOutput("sh_addr", obs_addr, 32'h0000_0010);
    checkOutput("sh_be", 32'(obs_be), 32'hC);

    applyStimulus(1'b0, 1'b0, 3'b100, 32'h0000_0040, 32'h0, 100, 0, 32'h1111_2222, 2);
    checkOutput("to_bus_error", 32'(obs_berr), 32'd1);
    checkOutput("to_rdata", obs_rdata, 32'd0);
    checkOutput("to_req_cycles", 32'(obs_done_reqs), 32'd16);

    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 1, 32'hCAFE_F00D, 1);

    // Reset lands while a load waits in RESP; the late response must be dropped.
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    funct3     = 3'b010;
    addr       = 32'h0000_0300;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    @(posedge clock); #1;
    bus.gnt = 1'b1;
    @(posedge clock); #1;
    bus.gnt  = 1'b0;
    mem_read = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    reset      = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1234_5678;
    @(negedge clock);
    checkOutput("rst_mid_stall", 32'(stall), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    checkOutput("rst_mid_req", 32'(bus.req), 32'd0);
    checkOutput("rst_mid_rdata", rdata, 32'd0);
    checkOutput("rst_mid_select", 32'(mem_select), 32'd0);
    @(posedge clock); #1;
    bus.rvalid = 1'b0;
    @(negedge clock);
    checkOutput("rst_late_done", 32'(done), 32'd0);
    checkOutput("rst_late_rdata", rdata, 32'd0);
    @(posedge clock); #1;
    m_rdata   = '0;
    m_bi      = '0;
    m_ms      = '0;
    obs_stall = 0;
    obs_req   = 0;

    for (int t = 0; t < 60; t++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = st ? store_f3[$urandom_range(0, 2)] : load_f3[$urandom_range(0, 4)];
      gd  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 3);
      rvd = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3);
      applyStimulus(st, 1'($urandom_range(0, 1)), f3, $urandom(), $urandom(), gd, rvd,
                    $urandom(), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
